// File: rtl/seq_gen_controller.sv
// Serial pattern sequencer: shifts a latched pattern MSB-first for repeat+1 runs with idle gaps between runs.
// Optional abort input and ABORT state are built only when SEQ_CTRL_ABORT_EN is defined.
module seq_gen_controller #(
    parameter int               SEQ_W       = 9,
    parameter logic [SEQ_W-1:0] DEF_PATTERN = 9'b100111001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_def,
    input  logic [SEQ_W-1:0] pattern_in,
    input  logic [3:0]       repeat_in,
    input  logic [3:0]       gap_in,
`ifdef SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             run_done,
    output logic             seq_done,
    output logic [2:0]       state_out,
    output logic [3:0]       bit_cnt
);

    localparam int         IDX_W = $clog2(SEQ_W);
    localparam logic [3:0] LAST  = 4'(SEQ_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3
`ifdef SEQ_CTRL_ABORT_EN
        , S_ABORT = 3'd4
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       bit_q, bit_d;
    logic [3:0]       run_q, run_d;     // runs still owed after the current one
    logic [3:0]       gap_q, gap_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [SEQ_W-1:0] pat_q, pat_d;

    logic             busy_q, busy_d;
    logic             sout_q, sout_d;
    logic             svld_q, svld_d;
    logic             rdone_q, rdone_d;
    logic             sdone_q, sdone_d;
    logic [2:0]       st_q, st_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            run_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            run_q   <= run_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            pat_q   <= pat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        run_d   = run_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        pat_d   = pat_q;
        case (state_q)
            S_IDLE: begin
                if (start_def || start) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                    run_d   = repeat_in;
                    gap_d   = gap_in;
                    pat_d   = start_def ? DEF_PATTERN : pattern_in;
                end
            end
            S_SHIFT: begin
`ifdef SEQ_CTRL_ABORT_EN
                if (abort) begin
                    state_d = S_ABORT;
                    bit_d   = '0;
                end else
`endif
                if (bit_q == LAST) begin
                    bit_d = '0;
                    if (run_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        run_d = run_q - 4'd1;
                        if (gap_q != '0) begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                        end
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_GAP: begin
`ifdef SEQ_CTRL_ABORT_EN
                if (abort) begin
                    state_d = S_ABORT;
                end else
`endif
                if (gcnt_q <= 4'd1) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
`ifdef SEQ_CTRL_ABORT_EN
            S_ABORT: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        idx     = IDX_W'(LAST - bit_d);
        busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP);
        svld_d  = (state_d == S_SHIFT);
        sout_d  = (state_d == S_SHIFT) ? pat_d[idx] : 1'b0;
        rdone_d = (state_d == S_SHIFT) && (bit_d == LAST);
        sdone_d = (state_d == S_DONE);
        st_d    = state_d;
        bcnt_d  = (state_d == S_SHIFT) ? bit_d : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
            svld_q  <= 1'b0;
            rdone_q <= 1'b0;
            sdone_q <= 1'b0;
            st_q    <= '0;
            bcnt_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            sout_q  <= sout_d;
            svld_q  <= svld_d;
            rdone_q <= rdone_d;
            sdone_q <= sdone_d;
            st_q    <= st_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign busy         = busy_q;
    assign serial_out   = sout_q;
    assign serial_valid = svld_q;
    assign run_done     = rdone_q;
    assign seq_done     = sdone_q;
    assign state_out    = st_q;
    assign bit_cnt      = bcnt_q;

endmodule

// File: tb/tb_seq_gen_controller.sv
// Scoreboard bench for seq_gen_controller: expected per-cycle outputs are queued from a run/bit/gap model.
module tb_seq_gen_controller;

    localparam logic [8:0] DEF = 9'b100111001;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       sout;
        logic       rdone;
        logic       sdone;
        logic [2:0] st;
        logic [3:0] bc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_def = 1'b0;
    logic [8:0] pattern_in = '0;
    logic [3:0] repeat_in = '0;
    logic [3:0] gap_in = '0;
    logic       abort = 1'b0;
    logic       busy, serial_out, serial_valid, run_done, seq_done;
    logic [2:0] state_out;
    logic [3:0] bit_cnt;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    seq_gen_controller dut (
        .clk(clk), .rst(rst), .start(start), .start_def(start_def),
        .pattern_in(pattern_in), .repeat_in(repeat_in), .gap_in(gap_in),
`ifdef SEQ_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .serial_out(serial_out), .serial_valid(serial_valid),
        .run_done(run_done), .seq_done(seq_done), .state_out(state_out), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic b, input logic v, input logic s, input logic rd,
                                input logic sd, input logic [2:0] st, input logic [3:0] bc);
        obs_t o;
        o.busy = b; o.valid = v; o.sout = s; o.rdone = rd; o.sdone = sd; o.st = st; o.bc = bc;
        return o;
    endfunction

    // Whole-sequence model: runs of 9 bits separated by gap idle cycles, then one DONE cycle.
    function automatic int push_seq(input logic [8:0] pat, input int rep, input int gp);
        int n = 0;
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < 9; i++) begin
                q.push_back(mk(1'b1, 1'b1, pat[8-i], i == 8, 1'b0, 3'd1, 4'(i)));
                n++;
            end
            if (r < rep)
                for (int g = 0; g < gp; g++) begin
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0));
                    n++;
                end
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd0));
        return n + 1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            obs_t act, exp_o;
            act   = {busy, serial_valid, serial_out, run_done, seq_done, state_out, bit_cnt};
            exp_o = (q.size() != 0) ? q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL out t=%0t actual b%0b v%0b s%0b rd%0b sd%0b st%0d bc%0d required b%0b v%0b s%0b rd%0b sd%0b st%0d bc%0d",
                         $time, act.busy, act.valid, act.sout, act.rdone, act.sdone, act.st, act.bc,
                         exp_o.busy, exp_o.valid, exp_o.sout, exp_o.rdone, exp_o.sdone, exp_o.st, exp_o.bc);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the DUT idle; returns number of queued cycles.
    task automatic issue(input bit use_def, input bit use_st, input logic [8:0] pat,
                         input logic [3:0] rep, input logic [3:0] gp, output int n);
        start = use_st; start_def = use_def;
        pattern_in = pat; repeat_in = rep; gap_in = gp;
        @(posedge clk);
        n = push_seq(use_def ? DEF : pat, int'(rep), int'(gp));
        #1;
        start = 1'b0; start_def = 1'b0;
        pattern_in = 9'($urandom); repeat_in = 4'($urandom); gap_in = 4'($urandom);
    endtask

    // Advance through the sequence; every start sampled here lands in SHIFT/GAP/DONE and must be ignored.
    task automatic run(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            start      = noise && ($urandom_range(0, 3) == 0);
            start_def  = noise && ($urandom_range(0, 5) == 0);
            pattern_in = 9'($urandom); repeat_in = 4'($urandom); gap_in = 4'($urandom);
            cycle();
        end
        start = 1'b0; start_def = 1'b0;
    endtask

    initial begin
        int n;
        cycle();
        mon_en = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        issue(1'b1, 1'b0, 9'h000, 4'd0, 4'd0, n); run(n, 1'b0);
        issue(1'b0, 1'b1, 9'h1A5, 4'd1, 4'd2, n); run(n, 1'b0);
        issue(1'b0, 1'b1, 9'h0F3, 4'd2, 4'd0, n); run(n, 1'b0);
        // back-to-back with start pulses during busy and DONE, then accepted right after DONE
        issue(1'b0, 1'b1, 9'h155, 4'd1, 4'd3, n); run(n, 1'b1);
        issue(1'b1, 1'b1, 9'h0AA, 4'd15, 4'd0, n); run(n, 1'b1);
        cycle();

        // reset while bit 4 is on the wire
        issue(1'b0, 1'b1, 9'h1C3, 4'd3, 4'd1, n);
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        q.delete();
        rst = 1'b0;
        cycle();
        issue(1'b0, 1'b1, 9'h03C, 4'd0, 4'd0, n); run(n, 1'b0);

`ifdef SEQ_CTRL_ABORT_EN
        issue(1'b0, 1'b1, 9'h1F0, 4'd1, 4'd3, n);
        repeat (9) cycle();
        abort = 1'b1;
        cycle();
        q.delete();
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0));
        abort = 1'b0;
        repeat (3) cycle();
`endif

        for (int k = 0; k < 25; k++) begin
            bit          d  = ($urandom_range(0, 3) == 0);
            bit          s  = !d || ($urandom_range(0, 1) == 1);
            logic [3:0]  rp = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            issue(d, s, 9'($urandom), rp, 4'($urandom), n);
            run(n, 1'b1);
            repeat ($urandom_range(0, 3)) cycle();
        end

        repeat (3) cycle();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
